// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing source and its consumers.
//   hsync, vsync   sync pulses, polarity set by the producer's parameters
//   display_on     high while (hpos, vpos) lies in the visible area
//   hpos, vpos     current pixel column / line, 10 bits each
//   line_start     one-cycle strobe at hpos == 0
//   frame_start    one-cycle strobe at hpos == 0 and vpos == 0
//   frame_count    frames completed since reset, wraps 255 -> 0
// Modports: master drives the bundle, slave observes it.
interface vga_timing_gen_if;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output hsync, vsync, display_on, hpos, vpos, line_start, frame_start, frame_count
  );

  modport slave (
    input hsync, vsync, display_on, hpos, vpos, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing source for the VGA output path, one pixel per clk.
// Ports:
//   clk    pixel clock, all logic on the rising edge
//   reset  synchronous, active-high; next state is pixel (0,0) with frame_count 0
//   vga    vga_timing_gen_if.master: hsync, vsync, display_on, hpos, vpos,
//          line_start, frame_start, frame_count
// Every output is a register decoded from the next pixel position, so all of
// them describe the hpos/vpos presented in the same cycle.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0
) (
  input logic              clk,
  input logic              reset,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
  end

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // 11-bit window bounds: a sync window may end exactly at 1024.
  localparam logic [10:0] H_DISP_END = 11'(H_DISPLAY);
  localparam logic [10:0] HS_START   = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] V_DISP_END = 11'(V_DISPLAY);
  localparam logic [10:0] VS_START   = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       hsync_q, vsync_q, disp_q, line_q, frame_q;
  logic       hs_act_d, vs_act_d, disp_d, line_d, frame_d;

  // Next pixel position and frame count.
  always_comb begin
    hpos_d = hpos_q + 10'd1;
    vpos_d = vpos_q;
    fcnt_d = fcnt_q;
    if (reset) begin
      hpos_d = '0;
      vpos_d = '0;
      fcnt_d = '0;
    end else if (hpos_q == H_LAST) begin
      hpos_d = '0;
      if (vpos_q == V_LAST) begin
        vpos_d = '0;
        fcnt_d = fcnt_q + 8'd1;
      end else begin
        vpos_d = vpos_q + 10'd1;
      end
    end
  end

  // Decode against the next position so the registered flags line up with hpos/vpos.
  always_comb begin
    hs_act_d = ({1'b0, hpos_d} >= HS_START) && ({1'b0, hpos_d} < HS_END);
    vs_act_d = ({1'b0, vpos_d} >= VS_START) && ({1'b0, vpos_d} < VS_END);
    disp_d   = ({1'b0, hpos_d} < H_DISP_END) && ({1'b0, vpos_d} < V_DISP_END);
    line_d   = (hpos_d == '0);
    frame_d  = (hpos_d == '0) && (vpos_d == '0);
  end

  always_ff @(posedge clk) begin
    hpos_q  <= hpos_d;
    vpos_q  <= vpos_d;
    fcnt_q  <= fcnt_d;
    hsync_q <= hs_act_d ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_q <= vs_act_d ? V_SYNC_POL : ~V_SYNC_POL;
    disp_q  <= disp_d;
    line_q  <= line_d;
    frame_q <= frame_d;
  end

  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.frame_count = fcnt_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = disp_q;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, a tiny 14x7 raster
// with active-high syncs, and a 14x525 raster exercising the default vertical
// timing). A reference model maps cycles-since-reset to the expected raster
// state; the stimulus pushes expectations, a monitor pops and compares.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;
  } exp_t;

  localparam int unsigned NONE = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();
  vga_timing_gen_if if2 ();

  vga_timing_gen dut0 (.clk(clk), .reset(rst0), .vga(if0));

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut1 (.clk(clk), .reset(rst1), .vga(if1));

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2)
  ) dut2 (.clk(clk), .reset(rst2), .vga(if2));

  exp_t q0[$], q1[$], q2[$];
  int unsigned pix [3];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Expected raster state after 'p' pixel clocks since the last reset.
  function automatic exp_t model(input int id, input int unsigned p);
    int unsigned hd, hf, hs, hb, vd, vf, vs, vb, ht, vt, pos, h, v;
    bit hp, vp;
    exp_t e;
    hd = 640; hf = 16; hs = 96; hb = 48; hp = 1'b0;
    vd = 480; vf = 10; vs = 2;  vb = 33; vp = 1'b0;
    if (id != 0) begin
      hd = 8; hf = 2; hs = 2; hb = 2;
    end
    if (id == 1) begin
      vd = 4; vf = 1; vs = 1; vb = 1; hp = 1'b1; vp = 1'b1;
    end
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    pos = p % (ht * vt);
    h   = pos % ht;
    v   = pos / ht;
    e.hpos        = 10'(h);
    e.vpos        = 10'(v);
    e.hsync       = (h >= hd + hf && h < hd + hf + hs) ? hp : !hp;
    e.vsync       = (v >= vd + vf && v < vd + vf + vs) ? vp : !vp;
    e.display_on  = (h < hd) && (v < vd);
    e.line_start  = (h == 0);
    e.frame_start = (pos == 0);
    e.frame_count = 8'((p / (ht * vt)) % 256);
    return e;
  endfunction

  task automatic set_rst(input int id, input logic r);
    case (id)
      0:       rst0 = r;
      1:       rst1 = r;
      default: rst2 = r;
    endcase
  endtask

  task automatic push(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // One clock per iteration: reset is forced, random (1 in 'rate'), or at pixel 'force_at'.
  task automatic stim(input int id, input int unsigned cycles, input bit hold,
                      input int unsigned rate, input int unsigned force_at);
    logic r;
    for (int unsigned c = 0; c < cycles; c++) begin
      @(negedge clk);
      r = hold || (pix[id] == force_at) || (rate != 0 && $urandom_range(rate - 1) == 0);
      set_rst(id, r);
      @(posedge clk);
      pix[id] = r ? 0 : pix[id] + 1;
      push(id, model(id, pix[id]));
    end
  endtask

  task automatic check(input int id, input exp_t got, input exp_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL dut%0d raster: got hs=%b vs=%b de=%b h=%0d v=%0d ls=%b fs=%b fc=%0d, want hs=%b vs=%b de=%b h=%0d v=%0d ls=%b fs=%b fc=%0d",
               id, got.hsync, got.vsync, got.display_on, got.hpos, got.vpos,
               got.line_start, got.frame_start, got.frame_count,
               want.hsync, want.vsync, want.display_on, want.hpos, want.vpos,
               want.line_start, want.frame_start, want.frame_count);
    end
  endtask

  initial begin
    exp_t a;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        a = '{if0.hsync, if0.vsync, if0.display_on, if0.hpos, if0.vpos,
              if0.line_start, if0.frame_start, if0.frame_count};
        check(0, a, q0.pop_front());
      end
      if (q1.size() > 0) begin
        a = '{if1.hsync, if1.vsync, if1.display_on, if1.hpos, if1.vpos,
              if1.line_start, if1.frame_start, if1.frame_count};
        check(1, a, q1.pop_front());
      end
      if (q2.size() > 0) begin
        a = '{if2.hsync, if2.vsync, if2.display_on, if2.hpos, if2.vpos,
              if2.line_start, if2.frame_start, if2.frame_count};
        check(2, a, q2.pop_front());
      end
    end
  end

  initial begin
    pix[0] = 0; pix[1] = 0; pix[2] = 0;
    fork
      begin
        stim(0, 3, 1'b1, 0, NONE);
        stim(0, 3000, 1'b0, 0, 1100);   // mid-line reset at hpos=300, vpos=1
        stim(0, 20000, 1'b0, 5000, NONE);
      end
      begin
        stim(1, 3, 1'b1, 0, NONE);
        stim(1, 256 * 98 + 20, 1'b0, 0, NONE);  // frame_count wraps 255 -> 0
        stim(1, 60, 1'b0, 0, 40);
        stim(1, 3000, 1'b0, 97, NONE);
      end
      begin
        stim(2, 3, 1'b1, 0, NONE);
        stim(2, 16000, 1'b0, 0, NONE);  // two full 525-line frames
        stim(2, 4000, 1'b0, 500, NONE);
      end
    join
    repeat (3) @(negedge clk);
    if (n_cmp < 12) begin
      n_bad++;
      $display("FAIL count: got %0d comparisons, want at least 12", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
